div_unit: RTL
=============

Name: div_unit

Overview:
- Multicycle signed divider for the MIPS-subset datapath; executes DIV (and the DIV step of DIVM) when the control unit asserts start.
- Responder on the control interface: it sources divby0flag and a done pulse back to the control FSM, and writes the HI/LO results.
- Restoring shift-subtract algorithm on operand magnitudes, one quotient bit per clock, followed by a sign fix-up cycle.

Parameters:
WIDTH, 32, operand/result width in bits; the counter width is derived from it as clog2(WIDTH)+1.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
a  input  WIDTH  dividend (rs), two's complement
b  input  WIDTH  divisor (rt), two's complement
hi  output  WIDTH  remainder register
lo  output  WIDTH  quotient register
busy  output  1  high in CALC and FIX
done  output  1  one-cycle pulse when hi/lo are updated
divby0flag  output  1  one-cycle pulse when start is accepted with b==0

Behaviour:
- Reset: asynchronous and active-high. Sets state to IDLE; hi, lo, busy, done and divby0flag to 0; internal registers to 0. Effective immediately, including mid-operation; the aborted division never produces done.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, b==0:
  - divby0flag=1 for the next cycle.
  - State stays IDLE; hi/lo unchanged; done stays 0.
- IDLE, start=1, b!=0:
  - Latch |a| into the dividend shift register and |b| into the divisor register; clear the remainder accumulator; count=0.
  - Latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB]; go to CALC.
- CALC, each cycle:
  - rem = {rem[WIDTH-2:0], dvd[MSB]}; dvd shifts left.
  - If rem >= divisor (unsigned): rem -= divisor and quotient bit = 1, shifted into dvd[0]; otherwise the bit is 0.
  - count++. After WIDTH iterations go to FIX.
- FIX:
  - lo = sign_q ? -q : q; hi = sign_r ? -rem : rem, modulo 2^WIDTH.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. A start seen in DONE is ignored.
- Latency: with start accepted at edge T0, hi/lo are valid and done=1 after edge T0+WIDTH+1 (33 cycles for WIDTH=32). Back-to-back starts are therefore separated by at least WIDTH+3 cycles.
- start in CALC, FIX or DONE is ignored; a and b need only be valid in the cycle start is accepted.
- Semantics match MIPS DIV: the quotient truncates toward zero and the remainder takes the sign of the dividend.
- Magnitudes are taken as unsigned WIDTH-bit values, so |0x80000000| = 0x80000000.
- 0x80000000 / -1 gives lo = 0x80000000 and hi = 0. This wraps without any flag; the divider has no overflow output.
- hi/lo hold their values until the next FIX or reset; a division-by-zero does not modify them.
- busy=1 exactly in CALC and FIX; done and divby0flag are never high in the same cycle.

Test Plan:
- Reset, then a=7, b=2, start for 1 cycle -> done pulse after exactly 33 cycles; lo=3, hi=1; busy high for 32+1 cycles.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=-2 -> lo=0xFFFFFFFD, hi=1. Then a=-7, b=-2 -> lo=3, hi=0xFFFFFFFF.
- Preload hi/lo via 100/7 (lo=14, hi=2), then a=5, b=0 with start -> divby0flag=1 for one cycle; done never asserts; hi=2, lo=14 unchanged; busy stays 0.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Also a=0x80000000, b=1 -> lo=0x80000000, hi=0.
- Start 100/7, assert reset at cycle 10 -> all outputs 0 immediately; no done. Then restart 100/7 -> lo=14, hi=2 after 33 cycles.
- Start 100/7, pulse start again at cycles 5 and 33 with a=1, b=1 -> both ignored; result lo=14, hi=2 with a single done pulse.

Source files
------------

// File: rtl/div_unit.sv
// Multicycle signed divider (restoring shift-subtract on magnitudes).
// One quotient bit per clock for WIDTH clocks, then a sign fix-up cycle
// that writes HI (remainder) and LO (quotient) with MIPS DIV semantics.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divby0flag
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ZERO_C   = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    // dvd holds the dividend magnitude and collects quotient bits from the right
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgnq_q, sgnq_d;
    logic             sgnr_q, sgnr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    // Two's-complement negation modulo 2^WIDTH
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + ONE_W;
    endfunction

    // Unsigned magnitude; the most negative value maps onto itself
    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    // Partial remainder can never overflow: it stays below |b| <= 2^(WIDTH-1)
    assign rem_sh  = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign rem_ge  = (rem_sh >= dvs_q);
    assign rem_sub = rem_sh - dvs_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b == ZERO_W) begin
                        dz_d = 1'b1;
                    end else begin
                        dvd_d   = mag_w(a);
                        dvs_d   = mag_w(b);
                        rem_d   = ZERO_W;
                        cnt_d   = ZERO_C;
                        sgnq_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        sgnr_d  = a[WIDTH-1];
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rem_d = rem_ge ? rem_sub : rem_sh;
                dvd_d = {dvd_q[WIDTH-2:0], rem_ge};
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                lo_d    = sgnq_q ? neg_w(dvd_q) : dvd_q;
                hi_d    = sgnr_q ? neg_w(rem_q) : rem_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous abort
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dvd_q   <= ZERO_W;
            dvs_q   <= ZERO_W;
            rem_q   <= ZERO_W;
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
            cnt_q   <= ZERO_C;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi         = hi_q;
    assign lo         = lo_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign divby0flag = dz_q;

endmodule
